// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared state encoding and output decode for the reset sequencer
package reset_sequencer_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_REL_SYS  = 3'd1,
        ST_REL_SENS = 3'd2,
        ST_REL_COMM = 3'd3,
        ST_RUN      = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic clk_en;
        logic sys_rst;
        logic sens_rst;
        logic comm_rst;
        logic done;
    } seq_out_t;

    // Each state fully determines the outputs, so release order follows state order by construction.
    function automatic seq_out_t decode_outputs(input seq_state_e st);
        seq_out_t o;
        o.clk_en   = (st != ST_HOLD);
        o.sys_rst  = (st == ST_HOLD) || (st == ST_REL_SYS);
        o.sens_rst = (st == ST_HOLD) || (st == ST_REL_SYS) || (st == ST_REL_SENS);
        o.comm_rst = (st != ST_RUN);
        o.done     = (st == ST_RUN);
        return o;
    endfunction

endpackage

// File: rtl/reset_sequencer_btn_debounce.sv
// rtl/reset_sequencer_btn_debounce.sv - two-flop synchroniser plus stable-count debouncer
module btn_debounce
    import reset_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 48000
) (
    input  logic CLK_48MHZ,
    input  logic RESET,
    input  logic BTN_IN,
    output logic BTN_LEVEL
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic [CW-1:0]          cnt_q;
    logic                   synced;

    assign synced    = sync_q[SYNC_STAGES-1];
    assign BTN_LEVEL = level_q;

    always_ff @(posedge CLK_48MHZ) begin
        if (RESET) begin
            sync_q  <= '1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], BTN_IN};
            if (synced == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                // This edge supplies the final differing sample of the run.
                level_q <= synced;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - debounced button front end and staged subsystem reset release
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter int HOLD_CYCLES     = 4800,
    parameter int STAGE_GAP       = 480
) (
    input  logic CLK_48MHZ,
    input  logic RESET,
    input  logic EXT_RESET_BTN,
    output logic CLK_EN,
    output logic SYS_RESET,
    output logic SENSOR_RESET,
    output logic COMM_RESET,
    output logic RESET_DONE
);

    localparam int MAXP = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW   = $clog2(MAXP + 1);

    logic       btn_level;
    seq_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    seq_out_t   out_q, out_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .CLK_48MHZ(CLK_48MHZ),
        .RESET    (RESET),
        .BTN_IN   (EXT_RESET_BTN),
        .BTN_LEVEL(btn_level)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!btn_level) begin
            // A held press freezes HOLD's count; anywhere else it restarts the sequence.
            if (state_q != ST_HOLD) begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        state_d = ST_REL_SYS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_REL_SYS, ST_REL_SENS, ST_REL_COMM: begin
                    if (cnt_q == CW'(STAGE_GAP - 1)) begin
                        state_d = seq_state_e'(state_q + 3'd1);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RUN: ;
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
        out_d = decode_outputs(state_d);
    end

    always_ff @(posedge CLK_48MHZ) begin
        if (RESET) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            out_q   <= decode_outputs(ST_HOLD);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign CLK_EN       = out_q.clk_en;
    assign SYS_RESET    = out_q.sys_rst;
    assign SENSOR_RESET = out_q.sens_rst;
    assign COMM_RESET   = out_q.comm_rst;
    assign RESET_DONE   = out_q.done;

endmodule
